// File: rtl/pwm_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_ramp_sequencer
//
// Drives one PWM pin. A prescaler turns clk_50MHz into a 1 us tick enable,
// and a period counter built on that tick defines the PWM period. A small FSM
// accepts ramp requests and moves the applied duty toward a target in fixed
// steps, one step every `rate` PWM periods. Duty only ever changes at a period
// boundary, so the pin never sees a truncated or glitched pulse.
//
// Ports
//   clk_50MHz     in   system clock
//   rst_n         in   asynchronous active-low reset
//   cfg_valid     in   ramp request valid
//   cfg_ready     out  request can be accepted (high only while idle)
//   cfg_target    in   target duty in ticks, clamped to PERIOD
//   cfg_step      in   duty change per update, 0 behaves as 1
//   cfg_rate      in   PWM periods between updates, 0 behaves as 1
//   abort         in   synchronous abort of an active ramp
//   pwm_out       out  registered PWM output
//   duty          out  duty currently applied
//   busy          out  ramp in progress (RAMP or DONE)
//   period_start  out  one-cycle pulse at the start of each PWM period
//   done_pulse    out  one-cycle pulse when duty reaches the target
// -----------------------------------------------------------------------------
module pwm_ramp_sequencer #(
   parameter int unsigned DIV    = 50,
   parameter int unsigned PERIOD = 200,
   parameter int unsigned DUTY_W = 8
) (
   input  logic              clk_50MHz,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DUTY_W-1:0] cfg_target,
   input  logic [DUTY_W-1:0] cfg_step,
   input  logic [7:0]        cfg_rate,
   input  logic              abort,
   output logic              pwm_out,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              period_start,
   output logic              done_pulse
);

   localparam int unsigned PSC_W  = (DIV    > 1) ? $clog2(DIV)    : 1;
   localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(DIV - 1);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PERIOD - 1);
   localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RAMP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PSC_W-1:0]    psc_q, psc_d;
   logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
   logic                period_start_q, period_start_d;
   logic                pwm_q, pwm_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic [DUTY_W-1:0]   target_q, target_d;
   logic [DUTY_W-1:0]   step_q, step_d;
   logic [7:0]          rate_q, rate_d;
   logic [7:0]          rate_cnt_q, rate_cnt_d;

   logic                tick;
   logic                pcnt_wrap;
   logic [DUTY_W-1:0]   cfg_target_clamped;
   logic [DUTY_W:0]     up_sum;
   logic [DUTY_W:0]     dn_diff;
   logic [DUTY_W-1:0]   duty_stepped;
   logic [7:0]          rate_cnt_inc;

   // -------------------------------------------------------------------------
   // Timebase: prescaler -> tick enable -> period counter -> PWM compare
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a value on every path (defaults
   // first), otherwise synthesis would infer latches.
   always_comb begin
      tick           = (psc_q == PSC_MAX);
      psc_d          = tick ? '0 : psc_q + 1'b1;
      pcnt_wrap      = tick && (pcnt_q == PCNT_MAX);
      pcnt_d         = pcnt_q;
      if (tick) begin
         pcnt_d = pcnt_wrap ? '0 : pcnt_q + 1'b1;
      end
      // Registered so the pulse lines up with the first cycle of pcnt == 0.
      period_start_d = pcnt_wrap;
      // duty == 0 never satisfies the compare; duty == PERIOD always does.
      pwm_d          = (DUTY_W'(pcnt_q) < duty_q);
   end

   // -------------------------------------------------------------------------
   // Ramp arithmetic, one bit wider than the duty so neither the step up can
   // wrap nor the step down can go below zero unnoticed.
   // -------------------------------------------------------------------------
   always_comb begin
      cfg_target_clamped = (cfg_target > DUTY_MAX) ? DUTY_MAX : cfg_target;
      up_sum             = {1'b0, duty_q} + {1'b0, step_q};
      dn_diff            = {1'b0, duty_q} - {1'b0, step_q};
      rate_cnt_inc       = rate_cnt_q + 8'd1;
      if (target_q > duty_q) begin
         duty_stepped = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
      end else begin
         // A set MSB means the subtraction borrowed: saturate at the target.
         duty_stepped = (dn_diff[DUTY_W] || (dn_diff <= {1'b0, target_q}))
                        ? target_q : dn_diff[DUTY_W-1:0];
      end
   end

   // -------------------------------------------------------------------------
   // Sequencer FSM, next-state and datapath updates
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      duty_d     = duty_q;
      target_d   = target_q;
      step_d     = step_q;
      rate_d     = rate_q;
      rate_cnt_d = rate_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               target_d   = cfg_target_clamped;
               step_d     = (cfg_step == '0)    ? DUTY_W'(1) : cfg_step;
               rate_d     = (cfg_rate == 8'd0)  ? 8'd1       : cfg_rate;
               rate_cnt_d = 8'd0;
               state_d    = (cfg_target_clamped == duty_q) ? S_DONE : S_RAMP;
            end
         end

         S_RAMP: begin
            // Abort takes priority over an update landing in the same cycle.
            if (abort) begin
               state_d = S_IDLE;
            end else if (period_start_q) begin
               if (rate_cnt_inc == rate_q) begin
                  rate_cnt_d = 8'd0;
                  duty_d     = duty_stepped;
                  if (duty_stepped == target_q) begin
                     state_d = S_DONE;
                  end
               end else begin
                  rate_cnt_d = rate_cnt_inc;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         psc_q          <= '0;
         pcnt_q         <= '0;
         period_start_q <= 1'b0;
         pwm_q          <= 1'b0;
         duty_q         <= '0;
         target_q       <= '0;
         step_q         <= '0;
         rate_q         <= 8'd0;
         rate_cnt_q     <= 8'd0;
      end else begin
         state_q        <= state_d;
         psc_q          <= psc_d;
         pcnt_q         <= pcnt_d;
         period_start_q <= period_start_d;
         pwm_q          <= pwm_d;
         duty_q         <= duty_d;
         target_q       <= target_d;
         step_q         <= step_d;
         rate_q         <= rate_d;
         rate_cnt_q     <= rate_cnt_d;
      end
   end

   // Status outputs decode straight from registers, so reset reaches the pins
   // without waiting for a clock edge.
   assign cfg_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign done_pulse   = (state_q == S_DONE);
   assign period_start = period_start_q;
   assign pwm_out      = pwm_q;
   assign duty         = duty_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_sequencer
//
// Bench for pwm_ramp_sequencer with a short timebase (DIV=5, PERIOD=10, so one
// PWM period is 50 clocks). Each scenario pushes the duty values it expects
// into a queue when it issues a request; a watcher pops one entry per observed
// duty change and also checks that the change follows a period_start after the
// programmed number of periods. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

   localparam int DIV    = 5;
   localparam int PERIOD = 10;
   localparam int DUTY_W = 8;
   localparam int PCLK   = DIV * PERIOD;

   logic              clk_50MHz = 1'b0;
   logic              rst_n;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [DUTY_W-1:0] cfg_target;
   logic [DUTY_W-1:0] cfg_step;
   logic [7:0]        cfg_rate;
   logic              abort;
   logic              pwm_out;
   logic [DUTY_W-1:0] duty;
   logic              busy;
   logic              period_start;
   logic              done_pulse;

   int n_total = 0;
   int n_pass  = 0;

   logic [DUTY_W-1:0] exp_q[$];

   always #10 clk_50MHz = ~clk_50MHz;

   pwm_ramp_sequencer #(
      .DIV    (DIV),
      .PERIOD (PERIOD),
      .DUTY_W (DUTY_W)
   ) dut (
      .clk_50MHz    (clk_50MHz),
      .rst_n        (rst_n),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_target   (cfg_target),
      .cfg_step     (cfg_step),
      .cfg_rate     (cfg_rate),
      .abort        (abort),
      .pwm_out      (pwm_out),
      .duty         (duty),
      .busy         (busy),
      .period_start (period_start),
      .done_pulse   (done_pulse)
   );

   // Issue one request; returns 1 ns after the accepting edge with the cfg
   // inputs scrambled so any late sampling shows up as a wrong duty.
   task automatic send_cfg(input logic [7:0] tgt, input logic [7:0] stp,
                           input logic [7:0] rte, input string name);
      int w;
      @(negedge clk_50MHz);
      cfg_target = tgt;
      cfg_step   = stp;
      cfg_rate   = rte;
      cfg_valid  = 1'b1;
      w = 0;
      while (!cfg_ready && w < 200) begin
         @(negedge clk_50MHz);
         w++;
      end
      n_total++;
      if (cfg_ready !== 1'b1) $display("FAIL %s accept: cfg_ready=%b required 1", name, cfg_ready);
      else n_pass++;
      @(posedge clk_50MHz);
      #1;
      cfg_valid  = 1'b0;
      cfg_target = 8'($urandom);
      cfg_step   = 8'($urandom);
      cfg_rate   = 8'($urandom);
   endtask

   // Pop one expected duty per observed change until the queue drains.
   task automatic watch_ramp(input int rate, input string name);
      logic [DUTY_W-1:0] prev_duty;
      logic [DUTY_W-1:0] exp_d;
      logic              prev_ps;
      int                ps_cnt, dones, cyc, budget;
      prev_duty = duty;
      prev_ps   = 1'b0;
      ps_cnt    = 0;
      dones     = 0;
      cyc       = 0;
      budget    = PCLK * rate * (exp_q.size() + 1) + 20;
      while (exp_q.size() > 0 && cyc < budget) begin
         @(negedge clk_50MHz);
         cyc++;
         if (done_pulse) dones++;
         if (duty !== prev_duty) begin
            exp_d = exp_q.pop_front();
            n_total++;
            if (duty !== exp_d) $display("FAIL %s duty: got %0d required %0d", name, duty, exp_d);
            else n_pass++;
            n_total++;
            if (!prev_ps || ps_cnt != rate)
               $display("FAIL %s update timing: got %0d period_starts (last one seen=%b) required %0d",
                        name, ps_cnt, prev_ps, rate);
            else n_pass++;
            ps_cnt = 0;
            if (exp_q.size() == 0) begin
               n_total++;
               if (done_pulse !== 1'b1)
                  $display("FAIL %s done with final duty: done_pulse=%b required 1", name, done_pulse);
               else n_pass++;
            end
         end
         if (period_start) ps_cnt++;
         prev_ps   = period_start;
         prev_duty = duty;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL %s timeout: %0d duty updates still pending after %0d clocks",
                  name, exp_q.size(), cyc);
         exp_q.delete();
      end
      @(negedge clk_50MHz);
      n_total++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1 || done_pulse !== 1'b0)
         $display("FAIL %s back to idle: busy=%b cfg_ready=%b done_pulse=%b required 0/1/0",
                  name, busy, cfg_ready, done_pulse);
      else n_pass++;
      n_total++;
      if (dones != 1) $display("FAIL %s done count: got %0d required 1", name, dones);
      else n_pass++;
   endtask

   task automatic count_pwm(input int exp_high, input string name);
      int high;
      high = 0;
      repeat (3) @(negedge clk_50MHz);
      for (int i = 0; i < PCLK; i++) begin
         @(negedge clk_50MHz);
         if (pwm_out === 1'b1) high++;
      end
      n_total++;
      if (high != exp_high)
         $display("FAIL %s pwm high clocks: got %0d of %0d required %0d", name, high, PCLK, exp_high);
      else n_pass++;
   endtask

   task automatic test_reset();
      int cyc, gap;
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_target = '0;
      cfg_step   = '0;
      cfg_rate   = '0;
      abort      = 1'b0;
      #5;
      n_total++;
      if (duty !== 8'd0 || pwm_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
          period_start !== 1'b0 || done_pulse !== 1'b0)
         $display("FAIL reset state: duty=%0d pwm=%b busy=%b ready=%b ps=%b done=%b required 0/0/0/1/0/0",
                  duty, pwm_out, busy, cfg_ready, period_start, done_pulse);
      else n_pass++;
      repeat (2) @(negedge clk_50MHz);
      rst_n = 1'b1;
      // Period length: distance between two period_start pulses.
      cyc = 0;
      while (period_start !== 1'b1 && cyc < 2 * PCLK) begin
         @(negedge clk_50MHz);
         cyc++;
      end
      gap = 0;
      do begin
         @(negedge clk_50MHz);
         gap++;
      end while (period_start !== 1'b1 && gap < 2 * PCLK);
      n_total++;
      if (gap != PCLK) $display("FAIL period length: got %0d clocks required %0d", gap, PCLK);
      else n_pass++;
      n_total++;
      if (duty !== 8'd0 || pwm_out !== 1'b0)
         $display("FAIL idle after reset: duty=%0d pwm=%b required 0/0", duty, pwm_out);
      else n_pass++;
   endtask

   task automatic test_ramp_up();
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd4);
      exp_q.push_back(8'd6);
      send_cfg(8'd6, 8'd2, 8'd1, "ramp_up");
      watch_ramp(1, "ramp_up");
      count_pwm(30, "ramp_up");
   endtask

   task automatic test_underflow();
      exp_q.push_back(8'd0);
      send_cfg(8'd0, 8'd255, 8'd1, "underflow");
      watch_ramp(1, "underflow");
      count_pwm(0, "underflow");
   endtask

   task automatic test_saturate();
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd6);
      exp_q.push_back(8'd7);
      send_cfg(8'd7, 8'd3, 8'd2, "saturate");
      watch_ramp(2, "saturate");
   endtask

   task automatic test_ramp_down();
      exp_q.push_back(8'd3);
      exp_q.push_back(8'd0);
      send_cfg(8'd0, 8'd4, 8'd0, "ramp_down");
      watch_ramp(1, "ramp_down");
      count_pwm(0, "ramp_down");
   endtask

   task automatic test_clamp();
      exp_q.push_back(8'd5);
      exp_q.push_back(8'd10);
      send_cfg(8'd15, 8'd5, 8'd1, "clamp");
      watch_ramp(1, "clamp");
      count_pwm(PCLK, "clamp");
   endtask

   // Target equal to current duty (12 clamps to 10): DONE at once, idle next.
   task automatic test_equal_target();
      send_cfg(8'd12, 8'd1, 8'd1, "equal");
      n_total++;
      if (done_pulse !== 1'b1 || busy !== 1'b1)
         $display("FAIL equal first clk: done_pulse=%b busy=%b required 1/1", done_pulse, busy);
      else n_pass++;
      @(posedge clk_50MHz);
      #1;
      n_total++;
      if (done_pulse !== 1'b0 || cfg_ready !== 1'b1 || duty !== 8'd10)
         $display("FAIL equal second clk: done_pulse=%b ready=%b duty=%0d required 0/1/10",
                  done_pulse, cfg_ready, duty);
      else n_pass++;
   endtask

   task automatic test_abort();
      int cyc, dones, changes;
      exp_q.push_back(8'd0);
      send_cfg(8'd0, 8'd10, 8'd1, "abort_prep");
      watch_ramp(1, "abort_prep");

      exp_q.push_back(8'd2);
      send_cfg(8'd8, 8'd2, 8'd1, "abort");
      cyc = 0;
      while (duty === 8'd0 && cyc < 2 * PCLK + 5) begin
         @(negedge clk_50MHz);
         cyc++;
      end
      n_total++;
      if (duty !== exp_q[0]) $display("FAIL abort first update: got %0d required %0d", duty, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      abort = 1'b1;
      @(posedge clk_50MHz);
      #1;
      abort = 1'b0;
      n_total++;
      if (busy !== 1'b0 || cfg_ready !== 1'b1)
         $display("FAIL abort to idle: busy=%b ready=%b required 0/1", busy, cfg_ready);
      else n_pass++;
      dones   = 0;
      changes = 0;
      for (int i = 0; i < 3 * PCLK; i++) begin
         @(negedge clk_50MHz);
         if (done_pulse === 1'b1) dones++;
         if (duty !== 8'd2) changes++;
      end
      n_total++;
      if (dones != 0 || changes != 0)
         $display("FAIL abort hold: %0d done pulses, %0d clocks with duty!=2, required 0/0", dones, changes);
      else n_pass++;

      exp_q.push_back(8'd4);
      send_cfg(8'd4, 8'd2, 8'd1, "after_abort");
      watch_ramp(1, "after_abort");
   endtask

   task automatic test_reset_mid_ramp();
      int cyc;
      exp_q.push_back(8'd3);
      send_cfg(8'd0, 8'd1, 8'd1, "mid_reset");
      cyc = 0;
      while (duty === 8'd4 && cyc < 2 * PCLK + 5) begin
         @(negedge clk_50MHz);
         cyc++;
      end
      n_total++;
      if (duty !== exp_q[0]) $display("FAIL mid_reset first update: got %0d required %0d", duty, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      @(negedge clk_50MHz);
      #3;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (duty !== 8'd0 || pwm_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
          done_pulse !== 1'b0)
         $display("FAIL mid_reset async: duty=%0d pwm=%b busy=%b ready=%b done=%b required 0/0/0/1/0",
                  duty, pwm_out, busy, cfg_ready, done_pulse);
      else n_pass++;
      repeat (2) @(negedge clk_50MHz);
      rst_n = 1'b1;
      repeat (2 * PCLK) @(negedge clk_50MHz);
      n_total++;
      if (duty !== 8'd0 || busy !== 1'b0)
         $display("FAIL mid_reset after release: duty=%0d busy=%b required 0/0", duty, busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_underflow();
      test_saturate();
      test_ramp_down();
      test_clamp();
      test_equal_target();
      test_abort();
      test_reset_mid_ramp();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
